// File: rtl/pdl_port_arbiter.sv
// Port-A arbiter for the PDL dual-port RAM: zero-fills the RAM after reset, then grants
// one CPU or bus/spy access per clock with CPU priority and a bus starvation override.
module pdl_port_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int INIT_CLEAR   = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_rvalid,
   output logic [DW-1:0] cpu_rdata,
   input  logic          bus_req,
   input  logic          bus_we,
   input  logic [AW-1:0] bus_addr,
   input  logic [DW-1:0] bus_wdata,
   output logic          bus_ack,
   output logic          bus_rvalid,
   output logic [DW-1:0] bus_rdata,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   output logic          ram_wren,
   output logic          ram_rden,
   input  logic [DW-1:0] ram_q,
   output logic          init_done
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [AW-1:0] LAST_ADDR = '1;
   localparam logic [7:0]    LIMIT     = 8'(STARVE_LIMIT);
   localparam bit            STARVE_EN = (STARVE_LIMIT != 0);

   state_t        state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;
   logic [7:0]    starve_cnt_q, starve_cnt_d;
   logic          rd_pend_q, rd_pend_d;
   logic          rd_owner_q, rd_owner_d;
   logic          init_done_q, init_done_d;
   logic          bus_win;
   logic          win_we;

   always_comb begin
      state_d     = state_q;
      clr_addr_d  = clr_addr_q;
      init_done_d = init_done_q;
      rd_pend_d   = 1'b0;
      rd_owner_d  = rd_owner_q;
      cpu_ack     = 1'b0;
      bus_ack     = 1'b0;
      ram_addr    = cpu_addr;
      ram_wdata   = cpu_wdata;
      ram_wren    = 1'b0;
      ram_rden    = 1'b0;
      bus_win     = bus_req && (!cpu_req || (STARVE_EN && (starve_cnt_q >= LIMIT)));
      win_we      = bus_win ? bus_we : cpu_we;

      case (state_q)
         ST_INIT: begin
            ram_addr  = clr_addr_q;
            ram_wdata = '0;
            ram_wren  = !reset;
            if (clr_addr_q == LAST_ADDR) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         default: begin
            if ((cpu_req || bus_req) && !reset) begin
               cpu_ack    = !bus_win;
               bus_ack    = bus_win;
               ram_wren   = win_we;
               ram_rden   = !win_we;
               rd_pend_d  = !win_we;
               rd_owner_d = bus_win;
               if (bus_win) begin
                  ram_addr  = bus_addr;
                  ram_wdata = bus_wdata;
               end
            end
         end
      endcase

      // The bus waits during zero-fill too, so its wait count carries into RUN.
      if (bus_req && !bus_ack) begin
         starve_cnt_d = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;
      end else begin
         starve_cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
         clr_addr_q   <= '0;
         starve_cnt_q <= 8'd0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= 1'b0;
         init_done_q  <= (INIT_CLEAR == 0);
      end else begin
         state_q      <= state_d;
         clr_addr_q   <= clr_addr_d;
         starve_cnt_q <= starve_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_owner_q   <= rd_owner_d;
         init_done_q  <= init_done_d;
      end
   end

   // Gating with reset drops a read that was in flight when reset arrived.
   assign cpu_rvalid = rd_pend_q && !rd_owner_q && !reset;
   assign bus_rvalid = rd_pend_q && rd_owner_q && !reset;
   assign cpu_rdata  = ram_q;
   assign bus_rdata  = ram_q;
   assign init_done  = init_done_q;

endmodule

// File: tb/tb_pdl_port_arbiter.sv
// Scoreboard bench for pdl_port_arbiter: a driver predicts grants and read data from a
// reference memory; a monitor pops expected read returns whenever the DUT presents rvalid.
module tb_pdl_port_arbiter;
   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int LIMIT = 4;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0, bus_req = 1'b0, bus_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0, bus_addr = '0;
   logic [DW-1:0] cpu_wdata = '0, bus_wdata = '0;
   logic          cpu_ack, cpu_rvalid, bus_ack, bus_rvalid;
   logic [DW-1:0] cpu_rdata, bus_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata, ram_q;
   logic          ram_wren, ram_rden, init_done;

   always #5 clk = ~clk;

   pdl_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT), .INIT_CLEAR(1)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_rden(ram_rden),
      .ram_q(ram_q), .init_done(init_done)
   );

   // Behavioural RAM with registered read, seeded with garbage so the zero-fill matters.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      if (ram_rden) ram_q <= mem[ram_addr];
   end

   typedef struct {
      bit            owner;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] ref_mem [DEPTH];
   int            n_cmp = 0, n_err = 0, cyc = 0;
   int            init_cnt = DEPTH;
   int            waited = 0;
   int            dut_bus_acks = 0;
   bit            last_cpu_ack = 1'b0, last_bus_ack = 1'b0;

   logic          s_cpu_req = 1'b0, s_cpu_we = 1'b0, s_bus_req = 1'b0, s_bus_we = 1'b0;
   logic [AW-1:0] s_cpu_addr = '0, s_bus_addr = '0;
   logic [DW-1:0] s_cpu_wdata = '0, s_bus_wdata = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: apply staged inputs, then check the combinational response against the model.
   task automatic step(input bit rst);
      bit            eb, ec, we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      @(posedge clk);
      #1;
      cyc++;
      reset = rst;
      cpu_req = s_cpu_req; cpu_we = s_cpu_we; cpu_addr = s_cpu_addr; cpu_wdata = s_cpu_wdata;
      bus_req = s_bus_req; bus_we = s_bus_we; bus_addr = s_bus_addr; bus_wdata = s_bus_wdata;
      #1;
      eb = 1'b0;
      ec = 1'b0;
      if (rst) begin
         chk("rst_acks", 64'({cpu_ack, bus_ack}), 64'd0);
         chk("rst_ram_en", 64'({ram_wren, ram_rden}), 64'd0);
         chk("rst_rvalid", 64'({cpu_rvalid, bus_rvalid}), 64'd0);
         sb.delete();
         init_cnt = 0;
         waited   = 0;
      end else if (init_cnt < DEPTH) begin
         chk("init_wren", 64'(ram_wren), 64'd1);
         chk("init_rden", 64'(ram_rden), 64'd0);
         chk("init_addr", 64'(ram_addr), 64'(init_cnt));
         chk("init_wdata", 64'(ram_wdata), 64'd0);
         chk("init_acks", 64'({cpu_ack, bus_ack}), 64'd0);
         chk("init_done_low", 64'(init_done), 64'd0);
         ref_mem[init_cnt] = '0;
         init_cnt++;
      end else begin
         chk("init_done_high", 64'(init_done), 64'd1);
         eb = s_bus_req && (!s_cpu_req || (LIMIT != 0 && waited >= LIMIT));
         ec = s_cpu_req && !eb;
         chk("cpu_ack", 64'(cpu_ack), 64'(ec));
         chk("bus_ack", 64'(bus_ack), 64'(eb));
         if (eb || ec) begin
            we = eb ? s_bus_we : s_cpu_we;
            a  = eb ? s_bus_addr : s_cpu_addr;
            d  = eb ? s_bus_wdata : s_cpu_wdata;
            chk("ram_wren", 64'(ram_wren), 64'(we));
            chk("ram_rden", 64'(ram_rden), 64'(!we));
            chk("ram_addr", 64'(ram_addr), 64'(a));
            if (we) begin
               chk("ram_wdata", 64'(ram_wdata), 64'(d));
               ref_mem[a] = d;
            end else begin
               sb.push_back('{eb, ref_mem[a], cyc + 1});
            end
         end else begin
            chk("idle_ram_en", 64'({ram_wren, ram_rden}), 64'd0);
         end
      end
      if (!rst) waited = (s_bus_req && !eb) ? ((waited < 255) ? waited + 1 : 255) : 0;
      last_cpu_ack = ec;
      last_bus_ack = eb;
      if (bus_ack) dut_bus_acks++;
   endtask

   task automatic idle(input int n);
      s_cpu_req = 1'b0;
      s_bus_req = 1'b0;
      repeat (n) step(1'b0);
   endtask

   // Requests are held until acknowledged, then replaced by a fresh random one.
   task automatic random_cycle();
      if (!s_cpu_req || last_cpu_ack) begin
         s_cpu_req   = 1'($urandom_range(0, 1));
         s_cpu_we    = 1'($urandom_range(0, 1));
         s_cpu_addr  = AW'($urandom_range(0, 15));
         s_cpu_wdata = $urandom;
      end
      if (!s_bus_req || last_bus_ack) begin
         s_bus_req   = 1'($urandom_range(0, 1));
         s_bus_we    = 1'($urandom_range(0, 1));
         s_bus_addr  = AW'($urandom_range(0, 15));
         s_bus_wdata = $urandom;
      end
      step(1'b0);
   endtask

   // Monitor: every cycle, rvalid must match the scoreboard head that is due now.
   initial begin
      bit exp_c, exp_b;
      forever begin
         @(negedge clk);
         exp_c = 1'b0;
         exp_b = 1'b0;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].owner) exp_b = 1'b1;
            else exp_c = 1'b1;
         end
         chk("cpu_rvalid", 64'(cpu_rvalid), 64'(exp_c));
         chk("bus_rvalid", 64'(bus_rvalid), 64'(exp_b));
         if (exp_c || exp_b) begin
            chk("rdata", 64'(sb[0].owner ? bus_rdata : cpu_rdata), 64'(sb[0].data));
            void'(sb.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

      // Zero-fill with both requesters asking the whole time; no ack may appear.
      s_cpu_req = 1'b1; s_cpu_we = 1'b0; s_cpu_addr = AW'(3);
      s_bus_req = 1'b1; s_bus_we = 1'b0; s_bus_addr = AW'(4);
      step(1'b1);
      repeat (DEPTH) step(1'b0);
      step(1'b0);  // bus has waited through init: saturated count forces a bus grant
      idle(2);

      // CPU write then read back at octal 17.
      s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_addr = AW'('o17); s_cpu_wdata = 32'h12345678;
      step(1'b0);
      s_cpu_we = 1'b0;
      step(1'b0);
      idle(2);

      // Both held high: four CPU grants then one bus grant, repeating.
      dut_bus_acks = 0;
      s_cpu_req = 1'b1; s_cpu_we = 1'b0; s_cpu_addr = AW'(1);
      s_bus_req = 1'b1; s_bus_we = 1'b0; s_bus_addr = AW'(2);
      repeat (15) step(1'b0);
      chk("starve_bus_grants", 64'(dut_bus_acks), 64'd3);
      idle(2);

      // Bus read at 5 followed by a CPU write at 5: the read returns the old value.
      s_bus_req = 1'b1; s_bus_we = 1'b0; s_bus_addr = AW'(5);
      step(1'b0);
      s_bus_req = 1'b0;
      s_cpu_req = 1'b1; s_cpu_we = 1'b1; s_cpu_addr = AW'(5); s_cpu_wdata = 32'hFFFFFFFF;
      step(1'b0);
      s_cpu_we = 1'b0;
      step(1'b0);
      idle(2);

      // Reset in the middle of zero-fill restarts it from address 0.
      step(1'b1);
      idle(300);
      step(1'b1);
      idle(DEPTH + 2);

      // Reset right after a CPU read ack drops the pending return.
      s_cpu_req = 1'b1; s_cpu_we = 1'b0; s_cpu_addr = AW'(5);
      step(1'b0);
      s_cpu_req = 1'b0;
      step(1'b1);
      idle(DEPTH + 2);

      // Randomized mixed traffic.
      repeat (2000) random_cycle();
      idle(3);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
